spi_master: RTL and testbench

- Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, fixed 8-bit frames; the initiator end for our spi_slave.
- Runs on the system clock and generates SCLK, SS and MOSI, and samples MISO.
- Controller side uses a start/busy handshake with a one-cycle data_valid pulse.
- Optional SS hold lets multi-byte transactions run without releasing SS.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_master.sv | 190 +++++++++++++++++++
 tb/tb_spi_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master/slave pair.
package spi_pkg;

  localparam int BYTE_SIZE   = 8;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_SS_GAP  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_WAIT_NEXT,
    ST_GAP
  } spi_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter: one-cycle tick every DIV enabled cycles.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  output logic tick_o
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      if (cnt_q == '0) cnt_d = RELOAD;
      else cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, with start/busy handshake
// and optional SS hold across back-to-back bytes.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SS_GAP  = DEF_SS_GAP
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [BYTE_SIZE-1:0] data_to_send,
  input  logic                 keep_ss,
  output logic                 busy,
  output logic [BYTE_SIZE-1:0] received_data,
  output logic                 data_valid,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic                 SS,
  input  logic                 MISO
);

  localparam int BW    = $clog2(BYTE_SIZE + 1);
  localparam int GAP_N = (SS_GAP < 1) ? 1 : SS_GAP;
  localparam int GW    = cnt_width(GAP_N);
  localparam logic [BW-1:0] LAST_BIT = BW'(BYTE_SIZE - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP_N - 1);

  spi_state_e state_q, state_d;

  logic [BYTE_SIZE-1:0] tx_q, tx_d;
  logic [BYTE_SIZE-1:0] rx_q, rx_d;
  logic [BYTE_SIZE-1:0] rdata_q, rdata_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [GW-1:0]        gap_q, gap_d;

  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic ss_q, ss_d;
  logic busy_q, busy_d;
  logic dv_q, dv_d;

  logic tick;
  logic div_en;
  logic div_load;

  assign div_en = (state_q == ST_SETUP) ||
                  (state_q == ST_XFER)  ||
                  (state_q == ST_HOLD);

  spi_clk_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .en_i  (div_en),
    .load_i(div_load),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ss_d     = ss_q;
    busy_d   = busy_q;
    dv_d     = 1'b0;
    div_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d     = data_to_send;
          mosi_d   = data_to_send[BYTE_SIZE-1];
          rx_d     = '0;
          bit_d    = '0;
          ss_d     = 1'b0;
          busy_d   = 1'b1;
          div_load = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) state_d = ST_XFER;
      end

      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[BYTE_SIZE-2:0], MISO};
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = tx_q << 1;
            if (bit_q == LAST_BIT) state_d = ST_HOLD;
            else mosi_d = tx_q[BYTE_SIZE-2];
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          rdata_d = rx_q;
          dv_d    = 1'b1;
          if (keep_ss) begin
            busy_d  = 1'b0;
            state_d = ST_WAIT_NEXT;
          end else begin
            ss_d    = 1'b1;
            gap_d   = GAP_LD;
            state_d = ST_GAP;
          end
        end
      end

      // SS stays asserted; a new start skips the setup phase
      ST_WAIT_NEXT: begin
        if (start) begin
          tx_d     = data_to_send;
          mosi_d   = data_to_send[BYTE_SIZE-1];
          rx_d     = '0;
          bit_d    = '0;
          busy_d   = 1'b1;
          div_load = 1'b1;
          state_d  = ST_XFER;
        end else if (!keep_ss) begin
          ss_d    = 1'b1;
          busy_d  = 1'b1;
          gap_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

  assign busy          = busy_q;
  assign received_data = rdata_q;
  assign data_valid    = dv_q;
  assign SCLK          = sclk_q;
  assign MOSI          = mosi_q;
  assign SS            = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a mode-0 slave model
// and expected-byte queues checked as frames complete.
module tb_spi_master;
  import spi_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_tests = 0;
  int n_fail = 0;

  // DUT with CLK_DIV=4
  logic       st4 = 1'b0;
  logic [7:0] d4 = 8'h00;
  logic       k4 = 1'b0;
  logic       busy4, dv4o, sclk4, mosi4, ss4;
  logic [7:0] rx4;
  logic       miso4 = 1'b0;

  // DUT with CLK_DIV=1
  logic       st1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       busy1, dv1o, sclk1, mosi1, ss1;
  logic [7:0] rx1;

  spi_master #(.CLK_DIV(4), .SS_GAP(2)) u4 (
    .CLK(CLK), .RESET_N(RESET_N),
    .start(st4), .data_to_send(d4), .keep_ss(k4),
    .busy(busy4), .received_data(rx4), .data_valid(dv4o),
    .SCLK(sclk4), .MOSI(mosi4), .SS(ss4), .MISO(miso4)
  );

  spi_master #(.CLK_DIV(1), .SS_GAP(2)) u1 (
    .CLK(CLK), .RESET_N(RESET_N),
    .start(st1), .data_to_send(d1), .keep_ss(1'b0),
    .busy(busy1), .received_data(rx1), .data_valid(dv1o),
    .SCLK(sclk1), .MOSI(mosi1), .SS(ss1), .MISO(1'b0)
  );

  logic [7:0] exp_tx4[$];
  logic [7:0] exp_rx4[$];
  logic [7:0] exp_tx1[$];
  logic [7:0] exp_rx1[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and slave model for u4
  logic       sclk4_p = 1'b0;
  logic       ss4_p = 1'b1;
  logic [7:0] slv_next = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] mb4 = 8'h00;
  int sl_cnt = 0, fb4 = 0;
  int rises4 = 0, ndv4 = 0, dvc4 = 0;
  int r4_first = 0, ssr4 = 0, ssr_cyc = 0;

  always @(posedge CLK) begin
    #1;
    if (!RESET_N) begin
      fb4 = 0;
      sl_cnt = 0;
    end
    if (!ss4 && ss4_p) begin
      sl_sh = slv_next;
      sl_cnt = 0;
      miso4 = sl_sh[7];
    end
    if (ss4 && !ss4_p) begin
      ssr4++;
      ssr_cyc = cyc;
    end
    if (sclk4 && !sclk4_p) begin
      rises4++;
      sl_cnt++;
      fb4++;
      mb4 = {mb4[6:0], mosi4};
      if (fb4 == 1) r4_first = cyc;
      if (fb4 == 8) begin
        fb4 = 0;
        chk("tx4_pending", 32'(exp_tx4.size() > 0), 32'd1);
        if (exp_tx4.size() > 0)
          chk("tx4_byte", 32'(mb4), 32'(exp_tx4.pop_front()));
      end
    end
    if (!sclk4 && sclk4_p) begin
      if (sl_cnt == 8) begin
        sl_sh = slv_next;
        sl_cnt = 0;
      end else begin
        sl_sh = sl_sh << 1;
      end
      miso4 = sl_sh[7];
    end
    if (dv4o) begin
      ndv4++;
      dvc4 = cyc;
      chk("rx4_pending", 32'(exp_rx4.size() > 0), 32'd1);
      if (exp_rx4.size() > 0)
        chk("rx4_byte", 32'(rx4), 32'(exp_rx4.pop_front()));
    end
    sclk4_p = sclk4;
    ss4_p = ss4;
  end

  // Monitor for u1
  logic       sclk1_p = 1'b0;
  logic [7:0] mb1 = 8'h00;
  int fb1 = 0, rises1 = 0, ndv1 = 0, dvc1 = 0;
  int r1_first = 0, tog1 = 0, t1_last = 0;

  always @(posedge CLK) begin
    #1;
    if (!RESET_N) fb1 = 0;
    if (sclk1 !== sclk1_p) begin
      tog1++;
      t1_last = cyc;
    end
    if (sclk1 && !sclk1_p) begin
      rises1++;
      fb1++;
      mb1 = {mb1[6:0], mosi1};
      if (fb1 == 1) r1_first = cyc;
      if (fb1 == 8) begin
        fb1 = 0;
        chk("tx1_pending", 32'(exp_tx1.size() > 0), 32'd1);
        if (exp_tx1.size() > 0)
          chk("tx1_byte", 32'(mb1), 32'(exp_tx1.pop_front()));
      end
    end
    if (dv1o) begin
      ndv1++;
      dvc1 = cyc;
      chk("rx1_pending", 32'(exp_rx1.size() > 0), 32'd1);
      if (exp_rx1.size() > 0)
        chk("rx1_byte", 32'(rx1), 32'(exp_rx1.pop_front()));
    end
    sclk1_p = sclk1;
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start4(input logic [7:0] d,
                        input logic [7:0] sres,
                        output int ks);
    d4 = d;
    slv_next = sres;
    st4 = 1'b1;
    exp_tx4.push_back(d);
    exp_rx4.push_back(sres);
    ks = cyc + 1;
    @(negedge CLK);
    st4 = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic wait_dv4(input int base, input string tag);
    int n = 0;
    while (ndv4 == base && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(ndv4 > base), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ks, ks2, r0, dv0, ssr0, n;

    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("por_ss", 32'(ss4), 32'd1);
    chk("por_busy", 32'(busy4), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // single frame 0xC1, slave returns 0x3A
    r0 = rises4;
    dv0 = ndv4;
    start4(8'hC1, 8'h3A, ks);
    chk("t2_ss_low", 32'(ss4), 32'd0);
    chk("t2_mosi_b7", 32'(mosi4), 32'd1);
    chk("t2_busy", 32'(busy4), 32'd1);
    wait_dv4(dv0, "t2_dv_timeout");
    chk("t2_dv_cycle", dvc4 - ks, 32'd72);
    chk("t2_first_rise", r4_first - ks, 32'd8);
    chk("t2_rises", rises4 - r0, 32'd8);
    chk("t2_rxdata", 32'(rx4), 32'h3A);
    wait_to(ks + 73);
    chk("t2_ss_high", 32'(ss4), 32'd1);
    chk("t2_busy_gap", 32'(busy4), 32'd1);
    wait_to(ks + 74);
    chk("t2_busy_done", 32'(busy4), 32'd0);
    chk("t2_dv_count", ndv4 - dv0, 32'd1);

    // reset values mid-simulation
    RESET_N = 1'b0;
    #1;
    chk("rst_ss", 32'(ss4), 32'd1);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_mosi", 32'(mosi4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_dv", 32'(dv4o), 32'd0);
    chk("rst_rxdata", 32'(rx4), 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // start while busy is ignored
    r0 = rises4;
    dv0 = ndv4;
    start4(8'hC1, 8'hE7, ks);
    wait_to(ks + 20);
    d4 = 8'h55;
    st4 = 1'b1;
    @(negedge CLK);
    st4 = 1'b0;
    d4 = 8'h00;
    wait_dv4(dv0, "t3_dv_timeout");
    wait_to(ks + 140);
    chk("t3_rises", rises4 - r0, 32'd8);
    chk("t3_dv_count", ndv4 - dv0, 32'd1);
    chk("t3_ss_idle", 32'(ss4), 32'd1);
    chk("t3_busy_idle", 32'(busy4), 32'd0);

    // back-to-back with SS held
    r0 = rises4;
    dv0 = ndv4;
    ssr0 = ssr4;
    k4 = 1'b1;
    start4(8'hA5, 8'h96, ks);
    slv_next = 8'h3C;
    wait_dv4(dv0, "t4_dv1_timeout");
    chk("t4_dv1_cycle", dvc4 - ks, 32'd72);
    chk("t4_wait_busy", 32'(busy4), 32'd0);
    chk("t4_wait_ss", 32'(ss4), 32'd0);
    start4(8'h0F, 8'h3C, ks2);
    k4 = 1'b0;
    wait_dv4(dv0 + 1, "t4_dv2_timeout");
    chk("t4_dv2_cycle", dvc4 - ks2, 32'd68);
    chk("t4_rises", rises4 - r0, 32'd16);
    chk("t4_dv_count", ndv4 - dv0, 32'd2);
    chk("t4_ss_rises", ssr4 - ssr0, 32'd1);
    chk("t4_ss_rise_at", ssr_cyc, dvc4);
    wait_to(ks2 + 80);

    // reset after the third rise
    r0 = rises4;
    dv0 = ndv4;
    start4(8'h77, 8'h11, ks);
    n = 0;
    while (rises4 - r0 < 3 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("t5_three_rises", rises4 - r0, 32'd3);
    RESET_N = 1'b0;
    #1;
    chk("t5_ss_async", 32'(ss4), 32'd1);
    chk("t5_sclk_async", 32'(sclk4), 32'd0);
    exp_tx4.delete();
    exp_rx4.delete();
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("t5_no_dv", ndv4 - dv0, 32'd0);
    r0 = rises4;
    start4(8'h81, 8'h42, ks);
    wait_dv4(dv0, "t5_dv_timeout");
    chk("t5_dv_cycle", dvc4 - ks, 32'd72);
    chk("t5_rises", rises4 - r0, 32'd8);
    chk("t5_rxdata", 32'(rx4), 32'h42);
    wait_to(ks + 80);

    // CLK_DIV=1, 0xFF out, MISO tied low
    r0 = rises1;
    dv0 = ndv1;
    n = tog1;
    d1 = 8'hFF;
    st1 = 1'b1;
    exp_tx1.push_back(8'hFF);
    exp_rx1.push_back(8'h00);
    ks = cyc + 1;
    @(negedge CLK);
    st1 = 1'b0;
    wait_to(ks + 25);
    chk("t6_dv_count", ndv1 - dv0, 32'd1);
    chk("t6_dv_cycle", dvc1 - ks, 32'd18);
    chk("t6_first_rise", r1_first - ks, 32'd2);
    chk("t6_toggles", tog1 - n, 32'd16);
    chk("t6_last_fall", t1_last - ks, 32'd17);
    chk("t6_rises", rises1 - r0, 32'd8);
    chk("t6_rxdata", 32'(rx1), 32'h00);
    chk("t6_ss_idle", 32'(ss1), 32'd1);
    chk("t6_busy_idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
